// File: rtl/mii_tx.sv
// Ethernet MII transmit framer: preamble/SFD, nibble-serial payload from a byte-wide
// AXI-Stream, zero padding to a minimum length, CRC-32 FCS and inter-frame gap.
module mii_tx #(
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_BYTES       = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       mii_tx_er,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StPad,
    StFcs,
    StIfg,
    StAbort
  } state_e;

  localparam int unsigned IfgCycles = 2 * IFG_BYTES;
  localparam logic [15:0] IfgLast   = (IfgCycles == 0) ? 16'd0 : 16'(IfgCycles - 1);
  localparam logic [31:0] CrcPoly   = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit   = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [7:0]  r_byte, w_byte_d;
  logic        r_hi, w_hi_d;
  logic        r_last, w_last_d;
  logic [15:0] r_bytes, w_bytes_d;
  logic [31:0] r_crc, w_crc_d;

  logic [3:0]  r_txd, w_txd_d;
  logic        r_tx_en, w_tx_en_d;
  logic        r_tx_er, w_tx_er_d;
  logic        r_tready, w_tready_d;
  logic        r_busy, w_busy_d;
  logic        r_underrun, w_underrun_d;

  logic        w_accept;
  logic        w_need_pad;
  logic        w_gap_end;
  logic        w_start;
  logic [15:0] w_bytes_inc;
  logic [31:0] w_fcs;

  assign w_accept    = r_tready & s_axis_tvalid;
  assign w_need_pad  = {16'd0, r_bytes} < MIN_FRAME_BYTES;
  assign w_bytes_inc = (r_bytes == 16'hFFFF) ? r_bytes : r_bytes + 16'd1;

  // Next-state logic; r_tready is the registered tready the upstream currently sees.
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_byte_d     = r_byte;
    w_hi_d       = r_hi;
    w_last_d     = r_last;
    w_bytes_d    = r_bytes;
    w_crc_d      = r_crc;
    w_underrun_d = 1'b0;
    w_gap_end    = 1'b0;
    w_start      = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_start = s_axis_tvalid;
      end

      StPreamble: begin
        if (r_cnt != 16'd15) begin
          w_cnt_d = r_cnt + 16'd1;
        end else if (w_accept) begin
          w_state_d = StData;
          w_byte_d  = s_axis_tdata;
          w_last_d  = s_axis_tlast;
          w_hi_d    = 1'b0;
          w_crc_d   = crc_byte(r_crc, s_axis_tdata);
          w_bytes_d = w_bytes_inc;
        end else begin
          w_state_d    = StAbort;
          w_underrun_d = 1'b1;
        end
      end

      StData: begin
        if (!r_hi) begin
          w_hi_d = 1'b1;
        end else if (r_last) begin
          if (w_need_pad) begin
            w_state_d = StPad;
            w_byte_d  = 8'h00;
            w_hi_d    = 1'b0;
            w_crc_d   = crc_byte(r_crc, 8'h00);
            w_bytes_d = w_bytes_inc;
          end else begin
            w_state_d = StFcs;
            w_cnt_d   = 16'd0;
          end
        end else if (w_accept) begin
          w_byte_d  = s_axis_tdata;
          w_last_d  = s_axis_tlast;
          w_hi_d    = 1'b0;
          w_crc_d   = crc_byte(r_crc, s_axis_tdata);
          w_bytes_d = w_bytes_inc;
        end else begin
          w_state_d    = StAbort;
          w_underrun_d = 1'b1;
        end
      end

      StPad: begin
        if (!r_hi) begin
          w_hi_d = 1'b1;
        end else if (w_need_pad) begin
          w_byte_d  = 8'h00;
          w_hi_d    = 1'b0;
          w_crc_d   = crc_byte(r_crc, 8'h00);
          w_bytes_d = w_bytes_inc;
        end else begin
          w_state_d = StFcs;
          w_cnt_d   = 16'd0;
        end
      end

      StFcs: begin
        if (r_cnt != 16'd7) begin
          w_cnt_d = r_cnt + 16'd1;
        end else if (IfgCycles == 0) begin
          w_gap_end = 1'b1;
        end else begin
          w_state_d = StIfg;
          w_cnt_d   = 16'd0;
        end
      end

      StIfg: begin
        if (r_cnt == IfgLast) begin
          w_gap_end = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end

      StAbort: begin
        // tready is held high here, so every valid beat is being discarded.
        if (s_axis_tvalid && s_axis_tlast) begin
          if (IfgCycles == 0) begin
            w_gap_end = 1'b1;
          end else begin
            w_state_d = StIfg;
            w_cnt_d   = 16'd0;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    // A frame already waiting at the end of the gap skips the idle cycle.
    if (w_gap_end) begin
      w_state_d = StIdle;
      w_start   = s_axis_tvalid;
    end
    if (w_start) begin
      w_state_d = StPreamble;
      w_cnt_d   = 16'd0;
      w_crc_d   = CrcInit;
      w_bytes_d = 16'd0;
      w_hi_d    = 1'b0;
      w_last_d  = 1'b0;
    end
  end

  assign w_fcs = ~w_crc_d;

  // Outputs are decoded from the next state so that they appear registered.
  always_comb begin
    w_txd_d    = 4'h0;
    w_tx_en_d  = 1'b0;
    w_tx_er_d  = 1'b0;
    w_tready_d = 1'b0;
    w_busy_d   = (w_state_d != StIdle);

    unique case (w_state_d)
      StPreamble: begin
        w_tx_en_d  = 1'b1;
        w_txd_d    = (w_cnt_d == 16'd15) ? 4'hD : 4'h5;
        w_tready_d = (w_cnt_d == 16'd15);
      end
      StData: begin
        w_tx_en_d  = 1'b1;
        w_txd_d    = w_hi_d ? w_byte_d[7:4] : w_byte_d[3:0];
        w_tready_d = w_hi_d & ~w_last_d;
      end
      StPad: begin
        w_tx_en_d = 1'b1;
        w_txd_d   = w_hi_d ? w_byte_d[7:4] : w_byte_d[3:0];
      end
      StFcs: begin
        w_tx_en_d = 1'b1;
        w_txd_d   = w_fcs[{w_cnt_d[2:0], 2'b00} +: 4];
      end
      StAbort: begin
        w_tx_en_d  = 1'b1;
        w_tx_er_d  = 1'b1;
        w_tready_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= 16'd0;
      r_byte     <= 8'd0;
      r_hi       <= 1'b0;
      r_last     <= 1'b0;
      r_bytes    <= 16'd0;
      r_crc      <= 32'd0;
      r_txd      <= 4'h0;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_tready   <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_byte     <= w_byte_d;
      r_hi       <= w_hi_d;
      r_last     <= w_last_d;
      r_bytes    <= w_bytes_d;
      r_crc      <= w_crc_d;
      r_txd      <= w_txd_d;
      r_tx_en    <= w_tx_en_d;
      r_tx_er    <= w_tx_er_d;
      r_tready   <= w_tready_d;
      r_busy     <= w_busy_d;
      r_underrun <= w_underrun_d;
    end
  end

  assign mii_txd       = r_txd;
  assign mii_tx_en     = r_tx_en;
  assign mii_tx_er     = r_tx_er;
  assign s_axis_tready = r_tready;
  assign busy          = r_busy;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_mii_tx.sv
// Bench for mii_tx: three instances (defaults, no padding, short gap) driven one at a time,
// wire traces compared against a table-driven CRC-32 frame model.
`timescale 1ns/1ps
module tb_mii_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [7:0] in_data  [3];
  logic       in_valid [3];
  logic       in_last  [3];
  logic       out_ready[3];
  logic [3:0] out_txd  [3];
  logic       out_en   [3];
  logic       out_er   [3];
  logic       out_busy [3];
  logic       out_ur   [3];

  mii_tx u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(in_data[0]), .s_axis_tvalid(in_valid[0]),
    .s_axis_tready(out_ready[0]), .s_axis_tlast(in_last[0]), .mii_txd(out_txd[0]),
    .mii_tx_en(out_en[0]), .mii_tx_er(out_er[0]), .busy(out_busy[0]), .underrun(out_ur[0])
  );

  mii_tx #(.MIN_FRAME_BYTES(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(in_data[1]), .s_axis_tvalid(in_valid[1]),
    .s_axis_tready(out_ready[1]), .s_axis_tlast(in_last[1]), .mii_txd(out_txd[1]),
    .mii_tx_en(out_en[1]), .mii_tx_er(out_er[1]), .busy(out_busy[1]), .underrun(out_ur[1])
  );

  mii_tx #(.IFG_BYTES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_axis_tdata(in_data[2]), .s_axis_tvalid(in_valid[2]),
    .s_axis_tready(out_ready[2]), .s_axis_tlast(in_last[2]), .mii_txd(out_txd[2]),
    .mii_tx_en(out_en[2]), .mii_tx_er(out_er[2]), .busy(out_busy[2]), .underrun(out_ur[2])
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;
  typedef struct {
    logic [3:0] txd;
    logic       en, er, ur, tready, busy;
    logic       hs, hs_last;
  } trace_t;

  beat_t       beats[$];
  trace_t      tr[$];
  int          seg_s[$];
  int          seg_l[$];
  logic [3:0]  exp_nib[$];
  logic [31:0] crc_tab[256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          drop_at = -1;
  int          rst_at = -1;
  int          drop_cyc = -1;
  bit          run_done;

  function automatic void init_crc_tab();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic void add_frame(input bq_t p);
    beat_t b;
    for (int i = 0; i < p.size(); i++) begin
      b.data = p[i];
      b.last = (i == p.size() - 1);
      beats.push_back(b);
    end
  endfunction

  // Expected wire nibbles: preamble+SFD, padded payload, FCS = ~CRC LSB first.
  function automatic void build_exp(input bq_t p, input int min_b);
    bq_t         b;
    logic [31:0] crc;
    logic [31:0] fcs;
    b = p;
    while (b.size() < min_b) b.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (b[i]) crc = crc_tab[8'(crc[7:0] ^ b[i])] ^ (crc >> 8);
    fcs = ~crc;
    exp_nib.delete();
    for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    foreach (b[i]) begin
      exp_nib.push_back(b[i][3:0]);
      exp_nib.push_back(b[i][7:4]);
    end
    for (int i = 0; i < 8; i++) exp_nib.push_back(4'(fcs >> (4 * i)));
  endfunction

  function automatic int first_diff(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      if (start + i >= tr.size() || i >= exp_nib.size()) return i;
      if (tr[start + i].txd !== exp_nib[i]) return i;
    end
    return -1;
  endfunction

  function automatic void find_segs();
    seg_s.delete();
    seg_l.delete();
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].en === 1'b1) begin
        if (i == 0 || tr[i - 1].en !== 1'b1) begin
          seg_s.push_back(i);
          seg_l.push_back(1);
        end else begin
          seg_l[seg_l.size() - 1] = seg_l[seg_l.size() - 1] + 1;
        end
      end
    end
  endfunction

  function automatic int quiet_len(input int from);
    int n = 0;
    while (from + n < tr.size() && tr[from + n].en === 1'b0 && tr[from + n].busy === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_er(input int from, input int len);
    int n = 0;
    for (int i = from; i < from + len && i < tr.size(); i++) if (tr[i].er !== 1'b0) n++;
    return n;
  endfunction

  function automatic int count_ur();
    int n = 0;
    foreach (tr[i]) if (tr[i].ur === 1'b1) n++;
    return n;
  endfunction

  function automatic int frame_len(input int n, input int min_b);
    return 16 + 2 * ((n > min_b) ? n : min_b) + 8;
  endfunction

  // Drives the queued beats into one instance and records one trace entry per cycle.
  task automatic run(input int sel, input int max_cyc);
    int     idx;
    int     idle;
    bit     dropped;
    trace_t t;
    logic   v;
    idx = 0; idle = 0; dropped = 0; run_done = 0; drop_cyc = -1;
    tr.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      t.txd = out_txd[sel]; t.en = out_en[sel]; t.er = out_er[sel]; t.ur = out_ur[sel];
      t.tready = out_ready[sel]; t.busy = out_busy[sel]; t.hs = 1'b0; t.hs_last = 1'b0;
      reset_n = (c == rst_at) ? 1'b0 : 1'b1;
      v = 1'b0;
      if (idx < beats.size()) begin
        if (idx == drop_at && t.tready === 1'b1 && !dropped) begin
          dropped = 1;
          drop_cyc = c;
        end else begin
          v = 1'b1;
          in_data[sel] = beats[idx].data;
          in_last[sel] = beats[idx].last;
          if (t.tready === 1'b1) begin
            t.hs = 1'b1;
            t.hs_last = beats[idx].last;
            idx++;
          end
        end
      end
      in_valid[sel] = v;
      tr.push_back(t);
      if (idx >= beats.size() && t.busy === 1'b0 && c > rst_at + 1) idle++;
      else idle = 0;
      if (idle >= 4) begin
        run_done = 1;
        break;
      end
    end
    in_valid[sel] = 1'b0;
    beats.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0; in_data[s] = 8'h00; in_last[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if ({out_txd[s], out_en[s], out_er[s], out_ready[s], out_busy[s], out_ur[s]} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %b required 0", s,
                 {out_txd[s], out_en[s], out_er[s], out_ready[s], out_busy[s], out_ur[s]});
      end
    end
  endtask

  task automatic test_known_crc();
    bq_t         p;
    logic [31:0] obs;
    int          e;
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    add_frame(p);
    run(1, 2000);
    find_segs();
    build_exp(p, 0);
    n_checks++;
    if (!run_done) begin n_fail++; $display("FAIL crc_timeout: run did not settle"); end
    n_checks++;
    if (seg_s.size() != 1) begin
      n_fail++; $display("FAIL crc_segments: got %0d required 1", seg_s.size());
    end else begin
      e = seg_s[0] + seg_l[0];
      n_checks++;
      if (seg_l[0] != 42) begin n_fail++; $display("FAIL crc_len: got %0d required 42", seg_l[0]); end
      n_checks++;
      if (first_diff(seg_s[0], exp_nib.size()) != -1) begin
        n_fail++; $display("FAIL crc_nibbles: first mismatch at %0d", first_diff(seg_s[0], 42));
      end
      obs = 32'd0;
      for (int i = 0; i < 8; i++) obs = obs | (32'(tr[e - 8 + i].txd) << (4 * i));
      n_checks++;
      if (obs !== 32'hCBF4_3926) begin
        n_fail++; $display("FAIL crc_fcs: got %h required cbf43926", obs);
      end
      n_checks++;
      if (quiet_len(e) != 24) begin
        n_fail++; $display("FAIL crc_ifg: got %0d required 24", quiet_len(e));
      end
    end
    n_checks++;
    if (count_ur() != 0 || count_er(0, tr.size()) != 0) begin
      n_fail++; $display("FAIL crc_err: underrun %0d tx_er %0d required 0 0", count_ur(),
                         count_er(0, tr.size()));
    end
  endtask

  task automatic test_pad();
    bq_t p;
    p.push_back(8'hAB);
    add_frame(p);
    run(0, 2000);
    find_segs();
    build_exp(p, 60);
    n_checks++;
    if (!run_done || seg_s.size() != 1) begin
      n_fail++; $display("FAIL pad_segments: got %0d required 1", seg_s.size());
    end else begin
      n_checks++;
      if (seg_l[0] != 144) begin n_fail++; $display("FAIL pad_len: got %0d required 144", seg_l[0]); end
      n_checks++;
      if (first_diff(seg_s[0], exp_nib.size()) != -1) begin
        n_fail++; $display("FAIL pad_nibbles: first mismatch at %0d", first_diff(seg_s[0], 144));
      end
      n_checks++;
      if (quiet_len(seg_s[0] + seg_l[0]) != 24) begin
        n_fail++; $display("FAIL pad_ifg: got %0d required 24", quiet_len(seg_s[0] + seg_l[0]));
      end
    end
  endtask

  // Frames streamed with tvalid held high; each frame and each gap checked.
  task automatic test_stream(input string name, input int sel, input int nfr, input int min_b,
                             input int gap, input int len_lo, input int len_hi);
    bq_t pl[4];
    for (int f = 0; f < nfr; f++) begin
      pl[f] = rand_payload($urandom_range(len_hi, len_lo));
      add_frame(pl[f]);
    end
    run(sel, 5000);
    find_segs();
    n_checks++;
    if (!run_done || seg_s.size() != nfr) begin
      n_fail++; $display("FAIL %s_segments: got %0d required %0d", name, seg_s.size(), nfr);
    end else begin
      for (int f = 0; f < nfr; f++) begin
        build_exp(pl[f], min_b);
        n_checks++;
        if (seg_l[f] != frame_len(pl[f].size(), min_b)) begin
          n_fail++; $display("FAIL %s_len[%0d]: got %0d required %0d", name, f, seg_l[f],
                             frame_len(pl[f].size(), min_b));
        end
        n_checks++;
        if (first_diff(seg_s[f], exp_nib.size()) != -1 || count_er(seg_s[f], seg_l[f]) != 0) begin
          n_fail++; $display("FAIL %s_nibbles[%0d]: first mismatch at %0d, tx_er count %0d", name,
                             f, first_diff(seg_s[f], exp_nib.size()), count_er(seg_s[f], seg_l[f]));
        end
        if (f > 0) begin
          n_checks++;
          if (seg_s[f] - (seg_s[f - 1] + seg_l[f - 1]) != gap) begin
            n_fail++; $display("FAIL %s_gap[%0d]: got %0d required %0d", name, f,
                               seg_s[f] - (seg_s[f - 1] + seg_l[f - 1]), gap);
          end
        end
      end
    end
  endtask

  task automatic test_underrun();
    bq_t a;
    bq_t b;
    int  t_last;
    int  bad;
    a = rand_payload(100);
    b = rand_payload(20);
    add_frame(a);
    add_frame(b);
    drop_at = 40;
    run(0, 3000);
    drop_at = -1;
    find_segs();
    n_checks++;
    if (!run_done) begin n_fail++; $display("FAIL ur_timeout: run did not settle"); end
    n_checks++;
    if (count_ur() != 1) begin n_fail++; $display("FAIL ur_count: got %0d required 1", count_ur()); end
    n_checks++;
    if (drop_cyc < 0 || seg_s.size() != 2) begin
      n_fail++; $display("FAIL ur_shape: drop %0d segments %0d required 2", drop_cyc, seg_s.size());
    end else begin
      build_exp(a, 60);
      n_checks++;
      if (drop_cyc != seg_s[0] + 95 || first_diff(seg_s[0], 96) != -1) begin
        n_fail++; $display("FAIL ur_prefix: drop cycle %0d required %0d, mismatch %0d", drop_cyc,
                           seg_s[0] + 95, first_diff(seg_s[0], 96));
      end
      n_checks++;
      if (tr[drop_cyc].er !== 1'b0 || tr[drop_cyc + 1].er !== 1'b1) begin
        n_fail++; $display("FAIL ur_er_start: got %b%b required 01", tr[drop_cyc].er,
                           tr[drop_cyc + 1].er);
      end
      t_last = -1;
      foreach (tr[i]) if (t_last < 0 && tr[i].hs === 1'b1 && tr[i].hs_last === 1'b1) t_last = i;
      bad = 0;
      for (int i = drop_cyc + 1; i <= t_last; i++) if (tr[i].er !== 1'b1 || tr[i].en !== 1'b1) bad++;
      n_checks++;
      if (t_last <= drop_cyc || bad != 0) begin
        n_fail++; $display("FAIL ur_abort: tlast at %0d, %0d cycles without tx_er", t_last, bad);
      end
      n_checks++;
      if (quiet_len(t_last + 1) != 24) begin
        n_fail++; $display("FAIL ur_ifg: got %0d required 24", quiet_len(t_last + 1));
      end
      build_exp(b, 60);
      n_checks++;
      if (seg_l[1] != 144 || first_diff(seg_s[1], exp_nib.size()) != -1
          || count_er(seg_s[1], seg_l[1]) != 0) begin
        n_fail++; $display("FAIL ur_next_frame: len %0d required 144, mismatch %0d", seg_l[1],
                           first_diff(seg_s[1], exp_nib.size()));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t a;
    bq_t b;
    a = rand_payload(10);
    b = rand_payload(5);
    add_frame(a);
    add_frame(b);
    // Frame A occupies cycles 1..144 with its FCS on 137..144; reset lands inside the FCS.
    rst_at = 140;
    run(0, 2000);
    rst_at = -1;
    find_segs();
    build_exp(a, 60);
    n_checks++;
    if (tr[0].en !== 1'b0 || tr[1].en !== 1'b1) begin
      n_fail++; $display("FAIL rst_start: got %b%b required 01", tr[0].en, tr[1].en);
    end
    n_checks++;
    if (first_diff(1, 140) != -1) begin
      n_fail++; $display("FAIL rst_before: first mismatch at %0d", first_diff(1, 140));
    end
    n_checks++;
    if ({tr[141].en, tr[141].busy, tr[141].tready, tr[141].er, tr[141].txd} !== 8'd0) begin
      n_fail++; $display("FAIL rst_after: got %b required 0",
                         {tr[141].en, tr[141].busy, tr[141].tready, tr[141].er, tr[141].txd});
    end
    n_checks++;
    if (tr[142].en !== 1'b1 || tr[142].txd !== 4'h5) begin
      n_fail++; $display("FAIL rst_restart: en %b txd %h required 1 5", tr[142].en, tr[142].txd);
    end
    build_exp(b, 60);
    n_checks++;
    if (!run_done || seg_s.size() != 2) begin
      n_fail++; $display("FAIL rst_segments: got %0d required 2", seg_s.size());
    end else if (seg_l[0] != 140 || seg_s[1] != 142 || seg_l[1] != 144
                 || first_diff(142, exp_nib.size()) != -1) begin
      n_fail++; $display("FAIL rst_frames: len0 %0d start1 %0d len1 %0d required 140 142 144",
                         seg_l[0], seg_s[1], seg_l[1]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    init_crc_tab();
    test_reset();
    test_known_crc();
    test_pad();
    test_stream("b2b", 0, 2, 60, 24, 64, 64);
    test_stream("rand", 0, 4, 60, 24, 1, 90);
    test_underrun();
    test_reset_midframe();
    test_stream("ifg2", 2, 2, 60, 4, 60, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_tx.md
Name: mii_tx

Overview:
- Ethernet MII transmit framer.
- Accepts a frame payload as a byte-wide AXI-Stream (destination MAC through end of payload).
- Emits preamble and SFD, then the payload nibble-serially on MII.
- Zero-pads the frame to a minimum length, appends the CRC-32 FCS, then enforces the inter-frame gap.
- Transmit-direction counterpart to the MII receive path; sits between the MAC stream logic and the PHY, clocked by the MII TX clock.

Parameters:
- MIN_FRAME_BYTES, 60, minimum bytes before FCS; shorter payloads are zero-padded; 0 disables padding.
- IFG_BYTES, 12, inter-frame gap in byte times (2*IFG_BYTES cycles).

Ports:
- clk  in  1  MII TX clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  last payload byte of frame.
- mii_txd  out  4  MII transmit nibble.
- mii_tx_en  out  1  MII transmit enable.
- mii_tx_er  out  1  MII transmit error.
- busy  out  1  high in any state except IDLE.
- underrun  out  1  one-cycle pulse on the cycle the underrun is detected.

Behaviour:
- Clock and reset:
  - All outputs are registered.
  - Reset (reset_n=0 at clk edge), also mid-frame: next cycle all outputs are 0 and the state is IDLE. No IFG follows a reset-aborted frame. CRC and counters are cleared.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG, ABORT.
- IDLE:
  - tready=0.
  - When tvalid=1, go to PREAMBLE. The byte is not consumed.
- PREAMBLE, 16 cycles:
  - tx_en=1; txd=0x5 for nibbles 1-15, 0xD for nibble 16 (7x 0x55 + SFD 0xD5, low nibble first).
  - tready=1 during nibble 16.
- Byte order and transfer:
  - Each byte takes 2 cycles: low nibble first, then high nibble.
  - The byte accepted on a tready cycle drives txd on the next 2 cycles.
  - tready=1 during the SFD nibble and during the high-nibble cycle of each payload byte, unless that byte had tlast=1.
- Underrun:
  - Any cycle with tready=1 and tvalid=0 is an underrun: pulse underrun and go to ABORT.
  - The next cycle has tx_en=1 and tx_er=1.
- ABORT:
  - tx_en=1, tx_er=1, txd=0.
  - tready=1 every cycle, discarding input until a beat with tvalid && tlast; then go to IFG.
- DATA after the tlast byte:
  - If bytes sent < MIN_FRAME_BYTES, go to PAD: 0x00 bytes until the count equals MIN_FRAME_BYTES.
  - Otherwise go directly to FCS.
  - The byte counter saturates at 2^16-1; frames have no maximum-length check.
- CRC:
  - CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers payload and pad bytes; preamble and SFD are excluded.
  - Updated once per byte.
- FCS, 8 cycles: transmits ~crc, least-significant byte first, low nibble first.
- IFG:
  - tx_en=0, txd=0 for 2*IFG_BYTES cycles; tready=0.
  - Then IDLE. A waiting tvalid starts PREAMBLE on the following cycle.
- Idle levels: tx_er=0 except in ABORT. txd=0 whenever tx_en=0.
- Frame length: 16 + 2*max(N, MIN_FRAME_BYTES) + 8 cycles of tx_en for an N-byte payload.
- Backpressure: tready is never asserted outside PREAMBLE nibble 16, DATA and ABORT.

Test Plan:
- MIN_FRAME_BYTES=0; stream ASCII "123456789" with tvalid held high -> tx_en high 42 cycles; nibbles 5x15, D, 1,3,2,3,...,9,3; FCS bytes 0x26,0x39,0xF4,0xCB; then 24 cycles tx_en=0; underrun never pulses.
- Defaults; 1-byte payload 0xAB with tlast -> 60 bytes on wire (0xAB then 59x 0x00) plus FCS; tx_en high 16+120+8=144 cycles; FCS matches bench CRC model.
- Defaults; 100-byte frame, tvalid dropped for one cycle at byte 40 -> underrun pulses once; tx_er=1 from next cycle until tlast is consumed; then 24 idle cycles; next frame transmits cleanly.
- Two 64-byte frames back-to-back with tvalid always high -> exactly 24 cycles of tx_en=0 between frames; second frame's preamble starts on cycle 25 after the first's last FCS nibble.
- reset_n=0 for 1 cycle during FCS -> next cycle tx_en=0, busy=0, tready=0; a new frame presented immediately starts preamble 1 cycle after tvalid with no IFG.
- IFG_BYTES=2, MIN_FRAME_BYTES=60; 60-byte frame -> no PAD state entered; exactly 4 idle cycles between frames.
